// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//
// Shared core definitions for the instruction fetch stage:
//   CORE_NOP_INSTR   bubble encoding (addi x0,x0,0). The all-zero word is a
//                    real opcode and is never treated as a bubble.
//   CORE_RESET_PC    default first byte address fetched after reset.
//   fetch_state_t    fetch FSM state encoding (RUN, JWAIT, REFILL).
//   word_align()     forces a byte address onto a 32-bit word boundary.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam logic [31:0] CORE_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] CORE_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_JWAIT  = 2'd1,
        ST_REFILL = 2'd2
    } fetch_state_t;

    // Redirect targets may arrive with stray low bits; fetch only ever
    // addresses whole words.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end in front of a synchronous instruction BRAM
// (read data returns one cycle after imem_en). Presents one instruction per
// cycle to decode, holds it across downstream stalls, and redirects on a
// branch mispredict or a resolved jalr.
//
// Parameters
//   RESET_PC       first byte address fetched after reset
//   NOP_INSTR      bubble presented whenever no valid instruction exists
//
// Ports
//   clk            clock, all state on the rising edge
//   rst            synchronous active-high reset
//   stall          downstream hold; presented instruction/PC must not change
//   branch_wrong   mispredict flush pulse (highest priority after rst)
//   branch_target  correct PC, valid with branch_wrong
//   stall_jalr     decode is holding a jalr; fetch waits for its target
//   jalr_done      jalr target resolved pulse
//   jalr_target    jalr destination, valid with jalr_done
//   imem_addr      word-aligned byte address to the BRAM
//   imem_en        BRAM read enable
//   imem_rdata     BRAM read data (one cycle after imem_en)
//   instr_raw      instruction presented to decode
//   pc_out         byte PC of instr_raw (0 while a bubble is presented)
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = CORE_RESET_PC,
    parameter logic [31:0] NOP_INSTR = CORE_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_wrong,
    input  logic [31:0] branch_target,
    input  logic        stall_jalr,
    input  logic        jalr_done,
    input  logic [31:0] jalr_target,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_raw,
    output logic [31:0] pc_out
);

    // Control state
    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         rd_valid;
    logic         rd_valid_d;
    logic         hold_valid;
    logic         hold_valid_d;

    // Data state (no reset needed: always qualified by a valid flag)
    logic [31:0]  rd_pc;
    logic [31:0]  rd_pc_d;
    logic [31:0]  hold_instr;
    logic [31:0]  hold_instr_d;
    logic [31:0]  hold_pc;
    logic [31:0]  hold_pc_d;

    // A BRAM read is launched at pc_q this cycle
    logic         issue;

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: branch_wrong > jalr_done > stall_jalr >
    // stall > normal advance (rst is applied in the register process).
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rd_valid_d   = 1'b0;
        rd_pc_d      = rd_pc;
        hold_valid_d = hold_valid;
        hold_instr_d = hold_instr;
        hold_pc_d    = hold_pc;
        issue        = 1'b0;

        if (branch_wrong) begin
            pc_d         = word_align(branch_target);
            hold_valid_d = 1'b0;
            state_d      = ST_REFILL;
        end else if (jalr_done) begin
            pc_d         = word_align(jalr_target);
            hold_valid_d = 1'b0;
            state_d      = ST_REFILL;
        end else begin
            unique case (state_q)
                ST_REFILL: begin
                    // First read at the new PC; a bubble is presented meanwhile.
                    issue   = 1'b1;
                    state_d = ST_RUN;
                end
                ST_JWAIT: begin
                    // Nothing fetched until the jalr target is known.
                    state_d = ST_JWAIT;
                end
                ST_RUN: begin
                    if (stall_jalr) begin
                        // The instruction behind the jalr is wrong-path: drop it
                        // and keep pc_q so nothing further is fetched.
                        hold_valid_d = 1'b0;
                        state_d      = ST_JWAIT;
                    end else if (stall) begin
                        // BRAM data is only valid for one cycle, so the
                        // presented instruction is captured on the first stall
                        // cycle and replayed from the hold register afterwards.
                        if (!hold_valid && rd_valid) begin
                            hold_valid_d = 1'b1;
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = rd_pc;
                        end
                    end else begin
                        // Release cycle still shows the hold contents while the
                        // read at pc_q lands next cycle: no gap, no repeat.
                        issue        = 1'b1;
                        hold_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_REFILL;
                end
            endcase
        end

        if (issue) begin
            rd_valid_d = 1'b1;
            rd_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REFILL;
            pc_q       <= RESET_PC;
            rd_valid   <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rd_valid   <= rd_valid_d;
            hold_valid <= hold_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        rd_pc      <= rd_pc_d;
        hold_instr <= hold_instr_d;
        hold_pc    <= hold_pc_d;
    end

    // -------------------------------------------------------------------------
    // Outputs. rst gates them directly so a bubble is shown from the very
    // first reset cycle, before the registers have been cleared.
    // -------------------------------------------------------------------------
    always_comb begin
        imem_addr = pc_q;
        imem_en   = issue && !rst;

        if (rst) begin
            instr_raw = NOP_INSTR;
            pc_out    = 32'd0;
        end else if (hold_valid) begin
            instr_raw = hold_instr;
            pc_out    = hold_pc;
        end else if (rd_valid) begin
            instr_raw = imem_rdata;
            pc_out    = rd_pc;
        end else begin
            instr_raw = NOP_INSTR;
            pc_out    = 32'd0;
        end
    end

endmodule
